// File: rtl/tsn_sched_pkg.sv
// Shared scheduler definitions for the TSN egress port schedulers.
//   DEF_PORT_FIFO_PRI_NUM : default number of priority FIFOs (vectors are +1 wide)
//   qvec_t                : per-queue vector, bit index = priority
//   sched_state_t         : arbiter FSM state, also exported for debug
package tsn_sched_pkg;

    localparam int DEF_PORT_FIFO_PRI_NUM = 8;
    localparam int QVEC_W                = DEF_PORT_FIFO_PRI_NUM + 1;

    typedef logic [QVEC_W-1:0] qvec_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_TX    = 2'd2
    } sched_state_t;

endpackage

// File: rtl/tsn_sp_sched_arb_if.sv
// Bundle between the strict-priority arbiter and its surroundings.
//   slave  : the arbiter (consumes queue/shaper/gate/beat inputs, drives grant)
//   master : the environment (shaper manager, fetch logic, egress beat tap)
//
// Grant handshake: o_scheduing_rst_vld is raised with o_scheduing_rst and both
// hold stable until the cycle in which i_sched_rdy is also 1; that cycle is the
// transfer. Validity is never withdrawn before the transfer, and i_sched_rdy is
// ignored whenever o_scheduing_rst_vld is low.
interface tsn_sp_sched_arb_if
    import tsn_sched_pkg::*;
#(
    parameter int PORT_FIFO_PRI_NUM = DEF_PORT_FIFO_PRI_NUM
);
    localparam int W = PORT_FIFO_PRI_NUM + 1;

    logic [W-1:0] i_fifoc_empty;
    logic [W-1:0] i_queque;
    logic         i_queque_vld;
    logic [W-1:0] i_gate_open;
    logic         i_sched_rdy;
    logic         i_pmac_tx_axis_valid;
    logic         i_pmac_tx_axis_last;
    logic [W-1:0] o_scheduing_rst;
    logic         o_scheduing_rst_vld;
    logic         o_busy;
    logic         o_stall_err;
    sched_state_t o_dbg_state;

    modport slave (
        input  i_fifoc_empty, i_queque, i_queque_vld, i_gate_open, i_sched_rdy,
        input  i_pmac_tx_axis_valid, i_pmac_tx_axis_last,
        output o_scheduing_rst, o_scheduing_rst_vld, o_busy, o_stall_err, o_dbg_state
    );

    modport master (
        output i_fifoc_empty, i_queque, i_queque_vld, i_gate_open, i_sched_rdy,
        output i_pmac_tx_axis_valid, i_pmac_tx_axis_last,
        input  o_scheduing_rst, o_scheduing_rst_vld, o_busy, o_stall_err, o_dbg_state
    );

endinterface

// File: rtl/tsn_pri_onehot_enc.sv
// Combinational highest-set-bit to one-hot encoder.
//   req    : request vector, higher index = higher priority
//   onehot : one-hot of the highest set bit of req, all zeros if req is zero
module tsn_pri_onehot_enc #(
    parameter int W = 9
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] onehot
);

    // Ascending scan: a later (higher) set bit overrides any earlier pick.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < W; i++) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tsn_sp_sched_arb.sv
// Strict-priority transmit scheduler for one TSN egress port.
// Grants the highest eligible queue (non-empty, shaper credit ok, gate open),
// holds the grant through the frame and releases it on the last beat or when
// no beat has been seen for STALL_TIMEOUT_CYC cycles.
//   i_clk, i_rst : port clock, synchronous active-high reset
//   bus (slave)  : queue/shaper/gate inputs, grant handshake, egress beat tap,
//                  busy/stall status and FSM state for debug
module tsn_sp_sched_arb
    import tsn_sched_pkg::*;
#(
    parameter int PORT_FIFO_PRI_NUM = DEF_PORT_FIFO_PRI_NUM,
    parameter int STALL_TIMEOUT_CYC = 4096
) (
    input  logic                i_clk,
    input  logic                i_rst,
    tsn_sp_sched_arb_if.slave   bus
);

    localparam int W  = PORT_FIFO_PRI_NUM + 1;
    localparam int CW = $clog2(STALL_TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STALL_TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [W-1:0]  shaper_mask;
    logic [W-1:0]  eligible;
    logic [W-1:0]  top_onehot;
    logic [W-1:0]  grant_q;
    logic          grant_vld_q;
    logic          busy_q;
    logic          stall_err_q;
    logic [CW-1:0] stall_cnt;
    sched_state_t  state;

    // The mask is loaded in every state; the IDLE decision reads the
    // registered copy, so a strobe only affects the following cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shaper_mask <= '1;
        end else if (bus.i_queque_vld) begin
            shaper_mask <= bus.i_queque;
        end
    end

    assign eligible = ~bus.i_fifoc_empty & shaper_mask & bus.i_gate_open;

    tsn_pri_onehot_enc #(.W(W)) u_enc (
        .req    (eligible),
        .onehot (top_onehot)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            grant_q     <= '0;
            grant_vld_q <= 1'b0;
            busy_q      <= 1'b0;
            stall_err_q <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            stall_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    stall_cnt <= '0;
                    if (eligible != '0) begin
                        grant_q     <= top_onehot;
                        grant_vld_q <= 1'b1;
                        state       <= ST_OFFER;
                    end
                end
                // Offer is sticky: queue state changes here do not retract it.
                ST_OFFER: begin
                    if (bus.i_sched_rdy) begin
                        grant_vld_q <= 1'b0;
                        busy_q      <= 1'b1;
                        stall_cnt   <= '0;
                        state       <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (bus.i_pmac_tx_axis_valid) begin
                        // A last beat wins over a coincident timeout.
                        stall_cnt <= '0;
                        if (bus.i_pmac_tx_axis_last) begin
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end else if (stall_cnt == CNT_LAST) begin
                        stall_err_q <= 1'b1;
                        grant_q     <= '0;
                        busy_q      <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (stall_cnt != CNT_MAX) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    grant_q     <= '0;
                    grant_vld_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_scheduing_rst     = grant_q;
    assign bus.o_scheduing_rst_vld = grant_vld_q;
    assign bus.o_busy              = busy_q;
    assign bus.o_stall_err         = stall_err_q;
    assign bus.o_dbg_state         = state;

endmodule

// File: tb/tb_tsn_sp_sched_arb.sv
module tb_tsn_sp_sched_arb;
    import tsn_sched_pkg::*;

    localparam int TO = 16;

    logic clk;
    logic rst;

    tsn_sp_sched_arb_if #(.PORT_FIFO_PRI_NUM(8)) bus ();

    tsn_sp_sched_arb #(
        .PORT_FIFO_PRI_NUM (8),
        .STALL_TIMEOUT_CYC (TO)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #2 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.i_fifoc_empty        = '1;
        bus.i_queque             = '1;
        bus.i_queque_vld         = 1'b0;
        bus.i_gate_open          = '1;
        bus.i_sched_rdy          = 1'b0;
        bus.i_pmac_tx_axis_valid = 1'b0;
        bus.i_pmac_tx_axis_last  = 1'b0;
    endtask

    task automatic load_mask(input logic [8:0] m);
        bus.i_queque     = m;
        bus.i_queque_vld = 1'b1;
        tick();
        bus.i_queque_vld = 1'b0;
    endtask

    // Wait (bounded) for an offer, then compare against the scoreboard head.
    task automatic expect_grant(input int budget, input string name);
        int waited;
        logic [8:0] exp;
        waited = 0;
        while (bus.o_scheduing_rst_vld !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h000;
        chk({name, "_vld"}, 32'(bus.o_scheduing_rst_vld), 32'd1);
        chk(name, 32'(bus.o_scheduing_rst), 32'(exp));
    endtask

    task automatic accept(input string name);
        bus.i_sched_rdy = 1'b1;
        tick();
        bus.i_sched_rdy = 1'b0;
        chk({name, "_acc_busy"}, 32'(bus.o_busy), 32'd1);
        chk({name, "_acc_vld"}, 32'(bus.o_scheduing_rst_vld), 32'd0);
    endtask

    // Sends n beats, last on the final one; returns cycles busy was seen.
    task automatic send_frame(input int n, output int busy_cyc);
        busy_cyc = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.o_busy === 1'b1) busy_cyc++;
            bus.i_pmac_tx_axis_valid = 1'b1;
            bus.i_pmac_tx_axis_last  = (i == n - 1);
            tick();
        end
        bus.i_pmac_tx_axis_valid = 1'b0;
        bus.i_pmac_tx_axis_last  = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [8:0] empty;
        logic [8:0] mask;
        logic [8:0] gate;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int idx);
        int bc;
        string nm;
        bit seen;
        nm = $sformatf("vec%0d", idx);
        bus.i_fifoc_empty = '1;
        load_mask(vecs[idx].mask);
        bus.i_fifoc_empty = vecs[idx].empty;
        bus.i_gate_open   = vecs[idx].gate;
        if (vecs[idx].exp != 9'h000) begin
            exp_q.push_back(vecs[idx].exp);
            expect_grant(1, nm);
            bus.i_fifoc_empty = '1;
            accept(nm);
            send_frame(1, bc);
            chk({nm, "_done_busy"}, 32'(bus.o_busy), 32'd0);
        end else begin
            seen = 1'b0;
            for (int c = 0; c < 5; c++) begin
                tick();
                if (bus.o_scheduing_rst_vld !== 1'b0) seen = 1'b1;
            end
            chk({nm, "_no_vld"}, 32'(seen), 32'd0);
        end
        bus.i_fifoc_empty = '1;
        bus.i_gate_open   = '1;
        tick();
    endtask

    // ---------------- test ----------------
    initial begin
        int bc;
        int first_err;
        int pulses;
        bit bad;

        vecs[0] = '{empty: 9'h1DB, mask: 9'h1FF, gate: 9'h1FF, exp: 9'h020};
        vecs[1] = '{empty: 9'h1DB, mask: 9'h1DF, gate: 9'h1FF, exp: 9'h004};
        vecs[2] = '{empty: 9'h1DB, mask: 9'h1FF, gate: 9'h1DF, exp: 9'h004};
        vecs[3] = '{empty: 9'h000, mask: 9'h1FF, gate: 9'h1FF, exp: 9'h100};
        vecs[4] = '{empty: 9'h1FE, mask: 9'h1FF, gate: 9'h1FF, exp: 9'h001};
        vecs[5] = '{empty: 9'h1DB, mask: 9'h1DB, gate: 9'h1FF, exp: 9'h000};
        vecs[6] = '{empty: 9'h000, mask: 9'h0AA, gate: 9'h00F, exp: 9'h008};
        vecs[7] = '{empty: 9'h000, mask: 9'h1FF, gate: 9'h000, exp: 9'h000};

        // Reset values
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_grant", 32'(bus.o_scheduing_rst), 32'd0);
        chk("rst_vld", 32'(bus.o_scheduing_rst_vld), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_stall", 32'(bus.o_stall_err), 32'd0);
        chk("rst_state", 32'(bus.o_dbg_state), 32'(ST_IDLE));
        rst = 1'b0;

        // All queues empty: nothing for 100 cycles
        bad = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.o_scheduing_rst_vld !== 1'b0 || bus.o_scheduing_rst !== 9'h000 ||
                bus.o_busy !== 1'b0 || bus.o_stall_err !== 1'b0) bad = 1'b1;
        end
        chk("empty_quiet", 32'(bad), 32'd0);

        // Queues 2 and 5: grant, 4-beat frame, regrant two cycles after last
        bus.i_fifoc_empty = 9'h1DB;
        exp_q.push_back(9'h020);
        expect_grant(1, "main_grant");
        accept("main");
        send_frame(4, bc);
        chk("main_busy_cyc", 32'(bc), 32'd4);
        chk("main_rel_busy", 32'(bus.o_busy), 32'd0);
        chk("main_rel_vld", 32'(bus.o_scheduing_rst_vld), 32'd0);
        chk("main_rel_state", 32'(bus.o_dbg_state), 32'(ST_IDLE));
        exp_q.push_back(9'h020);
        expect_grant(1, "main_regrant");
        bus.i_fifoc_empty = '1;
        accept("main2");
        send_frame(1, bc);
        tick();

        // Table-driven grant vectors
        for (int i = 0; i < 8; i++) run_vec(i);

        // Masked queue 5, unmask during TX, next grant returns to 5
        load_mask(9'h1DF);
        bus.i_fifoc_empty = 9'h1DB;
        exp_q.push_back(9'h004);
        expect_grant(1, "mask_grant");
        accept("mask");
        load_mask(9'h1FF);
        send_frame(1, bc);
        exp_q.push_back(9'h020);
        expect_grant(1, "unmask_grant");
        bus.i_fifoc_empty = '1;
        accept("unmask");
        send_frame(1, bc);
        tick();

        // Strobe coincident with the IDLE decision: old mask applies
        bus.i_fifoc_empty = 9'h1DB;
        bus.i_queque      = 9'h1DF;
        bus.i_queque_vld  = 1'b1;
        exp_q.push_back(9'h020);
        expect_grant(1, "oldmask_grant");
        bus.i_queque_vld  = 1'b0;
        bus.i_fifoc_empty = '1;
        accept("oldmask");
        send_frame(1, bc);
        load_mask(9'h1FF);

        // Offer holds while queue drains; beats in OFFER are ignored
        bus.i_fifoc_empty = 9'h1DB;
        exp_q.push_back(9'h020);
        expect_grant(1, "hold_grant");
        bus.i_fifoc_empty        = '1;
        bus.i_pmac_tx_axis_valid = 1'b1;
        bus.i_pmac_tx_axis_last  = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.o_scheduing_rst !== 9'h020 || bus.o_scheduing_rst_vld !== 1'b1) bad = 1'b1;
        end
        bus.i_pmac_tx_axis_valid = 1'b0;
        bus.i_pmac_tx_axis_last  = 1'b0;
        chk("hold_stable", 32'(bad), 32'd0);
        accept("hold");
        chk("hold_grant_kept", 32'(bus.o_scheduing_rst), 32'h020);
        send_frame(1, bc);
        tick();

        // Stall timeout: error pulse exactly TO cycles after entering TX
        bus.i_fifoc_empty = 9'h1DB;
        exp_q.push_back(9'h020);
        expect_grant(1, "stall_grant");
        bus.i_fifoc_empty = '1;
        accept("stall");
        first_err = -1;
        pulses    = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.o_stall_err === 1'b1) begin
                pulses++;
                if (first_err < 0) begin
                    first_err = k;
                    chk("stall_busy", 32'(bus.o_busy), 32'd0);
                    chk("stall_grant_clr", 32'(bus.o_scheduing_rst), 32'd0);
                    chk("stall_state", 32'(bus.o_dbg_state), 32'(ST_IDLE));
                end
            end
        end
        chk("stall_when", 32'(first_err), 32'(TO));
        chk("stall_pulses", 32'(pulses), 32'd1);

        // Last beat on the timeout cycle: normal completion
        bus.i_fifoc_empty = 9'h1DB;
        exp_q.push_back(9'h020);
        expect_grant(1, "edge_grant");
        bus.i_fifoc_empty = '1;
        accept("edge");
        bad = 1'b0;
        for (int k = 1; k < TO; k++) begin
            tick();
            if (bus.o_stall_err !== 1'b0) bad = 1'b1;
        end
        chk("edge_early_err", 32'(bad), 32'd0);
        chk("edge_still_busy", 32'(bus.o_busy), 32'd1);
        send_frame(1, bc);
        chk("edge_no_err", 32'(bus.o_stall_err), 32'd0);
        chk("edge_busy", 32'(bus.o_busy), 32'd0);
        tick();
        chk("edge_no_err2", 32'(bus.o_stall_err), 32'd0);

        // Reset mid-frame, then a fresh grant with the mask back to all ones
        load_mask(9'h1DF);
        bus.i_fifoc_empty = 9'h1DB;
        exp_q.push_back(9'h004);
        expect_grant(1, "mrst_grant");
        accept("mrst");
        bus.i_pmac_tx_axis_valid = 1'b1;
        tick();
        tick();
        bus.i_pmac_tx_axis_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_grant_clr", 32'(bus.o_scheduing_rst), 32'd0);
        chk("mrst_vld", 32'(bus.o_scheduing_rst_vld), 32'd0);
        chk("mrst_busy", 32'(bus.o_busy), 32'd0);
        chk("mrst_stall", 32'(bus.o_stall_err), 32'd0);
        chk("mrst_state", 32'(bus.o_dbg_state), 32'(ST_IDLE));
        exp_q.push_back(9'h020);
        expect_grant(1, "mrst_regrant");
        bus.i_fifoc_empty = '1;
        accept("mrst2");
        send_frame(2, bc);
        chk("mrst2_busy_cyc", 32'(bc), 32'd2);
        tick();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tsn_sp_sched_arb.md
# tsn_sp_sched_arb

Strict-priority transmit scheduler for one TSN egress port, sitting in the txmac scheduling pipeline between the per-queue credit-based shaper manager and the frame fetch logic. Each cycle it combines queue occupancy, shaper eligibility and gate state into an eligible vector. It grants the highest eligible priority queue as a one-hot result, holds that grant through the whole frame, and releases it on the last beat or on a stall timeout.

## Interface
Parameters:
- PORT_FIFO_PRI_NUM, 8, number of priority FIFOs; all vectors are PORT_FIFO_PRI_NUM+1 bits, bit index = priority, highest index wins
- STALL_TIMEOUT_CYC, 4096, max cycles without a valid beat while a frame is in flight

Ports (the only fixed choices: one clock; reset is synchronous and active-high):
- i_clk  in  1  250MHz port clock
- i_rst  in  1  synchronous active-high reset
- i_fifoc_empty  in  PORT_FIFO_PRI_NUM+1  per-queue CROSSBAR FIFO empty flags
- i_queque  in  PORT_FIFO_PRI_NUM+1  shaper eligibility vector (1 = credit satisfied)
- i_queque_vld  in  1  load strobe for i_queque
- i_gate_open  in  PORT_FIFO_PRI_NUM+1  per-queue transmission gate state
- i_sched_rdy  in  1  fetch logic accepts the current grant
- i_pmac_tx_axis_valid  in  1  egress beat valid
- i_pmac_tx_axis_last  in  1  egress last beat of frame
- o_scheduing_rst  out  PORT_FIFO_PRI_NUM+1  one-hot granted queue
- o_scheduing_rst_vld  out  1  grant offered
- o_busy  out  1  frame in flight
- o_stall_err  out  1  one-cycle pulse on timeout abort

## Operation
- Shaper mask register: reset to all ones. Loaded from i_queque on any cycle with i_queque_vld=1, in every state.
- eligible = ~i_fifoc_empty & shaper_mask & i_gate_open. Uses the registered mask, so a strobe in cycle N takes effect in cycle N+1.
- FSM IDLE / OFFER / TX.
- IDLE: if eligible≠0, latch the one-hot of its highest set bit into o_scheduing_rst and go to OFFER. Otherwise stay.
- OFFER: o_scheduing_rst_vld=1. The result stays stable until i_sched_rdy=1; there is no withdrawal even if the queue goes empty or ineligible. On i_sched_rdy=1, go to TX and clear vld.
- TX: o_busy=1. Stall counter clears on each cycle with i_pmac_tx_axis_valid=1; otherwise it increments.
  - valid&last: go to IDLE and clear o_scheduing_rst.
  - Counter reaches STALL_TIMEOUT_CYC-1 with no valid: pulse o_stall_err, go to IDLE and clear o_scheduing_rst.
- Beats arriving in IDLE or OFFER are ignored.
- Counter width is $clog2(STALL_TIMEOUT_CYC+1). It saturates and never wraps.

## Timing
- Reset values: o_scheduing_rst=0, o_scheduing_rst_vld=0, o_busy=0, o_stall_err=0, mask=all ones, state=IDLE, counter=0.
- Reset mid-frame: next cycle is IDLE with all outputs at reset values; no error pulse.
- Grant latency: eligible nonzero in IDLE at cycle N → o_scheduing_rst_vld=1 at N+1.
- Accept: i_sched_rdy=1 at cycle M in OFFER → vld=0 and o_busy=1 at M+1.
- Release: last beat at cycle K → o_busy=0 and state IDLE at K+1. The earliest next grant vld is at K+2; there is no zero-bubble back-to-back grant.
- A last beat together with the timeout in the same cycle counts as normal completion; no o_stall_err.
- Simultaneous i_queque_vld and an IDLE decision: the decision uses the old mask.

## Structure
- Shared package tsn_sched_pkg:
  - FSM state enum
  - PORT_FIFO_PRI_NUM default
  - qvec_t width typedef shared with the shaper manager
- Sub-module tsn_pri_onehot_enc: combinational highest-set-bit to one-hot encoder, parameterised by width. It is reused by other port schedulers.

## Test plan
- Reset, then i_fifoc_empty=9'h1FF → no vld for 100 cycles; all outputs 0.
- Queues 2 and 5 non-empty, mask and gate all ones → vld one cycle later with o_scheduing_rst=9'h020. i_sched_rdy, 4 beats with last on the 4th → o_busy for 4 cycles. Regrant 9'h020 two cycles after last.
- Same stimulus with i_queque=9'h1DF strobed → grant 9'h004. Strobe 9'h1FF during TX → the next grant is 9'h020.
- In OFFER with grant 9'h020, queue 5 goes empty before rdy → o_scheduing_rst stays 9'h020 until i_sched_rdy.
- STALL_TIMEOUT_CYC=16, grant accepted, no beats → o_stall_err pulses exactly 16 cycles after entering TX, then IDLE.
- i_rst asserted in the middle of TX → all outputs 0 the next cycle; a fresh grant follows normally after reset is released.
